// File: rtl/trig_sequencer.sv
// Trigger sequencer: issues bursts of one-cycle triggers spaced by a period,
// with overrun tracking. Optional external start via macro TRIG_SEQ_EXT_START_EN.
module trig_sequencer #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] count,
  input  logic               ext_trig,
  input  logic               pulser_busy,
  input  logic               overrun_clr,
  output logic               trig_out,
  output logic               running,
  output logic               done,
  output logic               overrun,
  output logic [BURST_W-1:0] fired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic [BURST_W-1:0] fired_q, fired_d;
  logic               trig_q, trig_d;
  logic               done_q, done_d;
  logic               run_q, run_d;
  logic               ovr_q, ovr_d;
  logic               start_s;
  logic [CNT_W-1:0]   period_clamped_s;
  logic [BURST_W-1:0] fired_inc_s;

`ifdef TRIG_SEQ_EXT_START_EN
  // Two synchronizer stages plus one history stage for rising-edge detection.
  logic [2:0] ext_sync_q;
  logic       ext_rise_s;

  // External trigger synchronizer and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync_q <= 3'b000;
    end else begin
      ext_sync_q <= {ext_sync_q[1:0], ext_trig};
    end
  end

  assign ext_rise_s = ext_sync_q[1] & ~ext_sync_q[2];
  assign start_s    = start | ext_rise_s;
`else
  logic ext_trig_unused_s;
  assign ext_trig_unused_s = ext_trig;
  assign start_s           = start;
`endif

  assign period_clamped_s = (period < PERIOD_MIN) ? PERIOD_MIN : period;
  assign fired_inc_s      = fired_q + BURST_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    fired_d  = fired_q;
    trig_d   = 1'b0;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    case (state_q)
      IDLE: begin
        if (start_s && !stop) begin
          period_d = period_clamped_s;
          count_d  = count;
          fired_d  = '0;
          state_d  = FIRE;
        end else begin
          state_d = IDLE;
        end
      end
      FIRE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pulser_busy) begin
          // A set in the same cycle as a clear wins.
          ovr_d = 1'b1;
        end else begin
          trig_d  = 1'b1;
          fired_d = fired_inc_s;
          cnt_d   = period_q - CNT_W'(1);
          if ((count_q != '0) && (fired_inc_s == count_q)) begin
            state_d = DRAIN;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = FIRE;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pulser_busy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    run_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      fired_q  <= '0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      fired_q  <= fired_d;
      trig_q   <= trig_d;
      done_q   <= done_d;
      run_q    <= run_d;
      ovr_q    <= ovr_d;
    end
  end

  assign trig_out = trig_q;
  assign done     = done_q;
  assign running  = run_q;
  assign overrun  = ovr_q;
  assign fired    = fired_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Scoreboard bench for trig_sequencer: expected trigger/done cycles are queued
// when stimulus is applied and popped as the DUT pulses its outputs.
module tb_trig_sequencer;
  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [CNT_W-1:0]   period = 32'd5;
  logic [BURST_W-1:0] count = 16'd3;
  logic               ext_trig = 1'b0;
  logic               pulser_busy = 1'b0;
  logic               overrun_clr = 1'b0;
  logic               trig_out;
  logic               running;
  logic               done;
  logic               overrun;
  logic [BURST_W-1:0] fired;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int t0;
  int exp_trig_q[$];
  int exp_done_q[$];

  trig_sequencer #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .period(period), .count(count), .ext_trig(ext_trig),
    .pulser_busy(pulser_busy), .overrun_clr(overrun_clr),
    .trig_out(trig_out), .running(running), .done(done),
    .overrun(overrun), .fired(fired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Pop the scoreboard whenever the DUT pulses trig_out or done
  always @(negedge clk) begin
    if (trig_out === 1'b1) begin
      if (exp_trig_q.size() == 0) check("trig_unexpected", cyc, -1);
      else check("trig_cycle", cyc, exp_trig_q.pop_front());
    end
    if (done === 1'b1) begin
      if (exp_done_q.size() == 0) check("done_unexpected", cyc, -1);
      else check("done_cycle", cyc, exp_done_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic drained(input string tag);
    check({tag, "_trig_pending"}, exp_trig_q.size(), 0);
    check({tag, "_done_pending"}, exp_done_q.size(), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_trig"}, int'(trig_out), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_fired"}, int'(fired), 0);
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    check_idle_zero("reset");
    rst = 1'b0;
    step(1);

    // Burst of 3 at period 5; mid-run config change and start are ignored
    period = 32'd5; count = 16'd3; t0 = cyc;
    exp_trig_q.push_back(t0 + 2); exp_trig_q.push_back(t0 + 7);
    exp_trig_q.push_back(t0 + 12); exp_done_q.push_back(t0 + 13);
    pulse_start();
    period = 32'd9; count = 16'd7;
    step(3);
    check("basic_running", int'(running), 1);
    pulse_start();
    step(15);
    check("basic_fired", int'(fired), 3);
    check("basic_idle", int'(running), 0);
    step(5);
    check("fired_hold", int'(fired), 3);
    drained("basic");

    // Period 1 is clamped to 2
    period = 32'd1; count = 16'd2; t0 = cyc;
    exp_trig_q.push_back(t0 + 2); exp_trig_q.push_back(t0 + 4);
    exp_done_q.push_back(t0 + 5);
    pulse_start();
    step(10);
    check("clamp_fired", int'(fired), 2);
    drained("clamp");

    // Busy for 3 cycles at the second slot delays it; overrun is sticky
    period = 32'd5; count = 16'd4; t0 = cyc;
    exp_trig_q.push_back(t0 + 2); exp_trig_q.push_back(t0 + 10);
    exp_trig_q.push_back(t0 + 15); exp_trig_q.push_back(t0 + 20);
    exp_done_q.push_back(t0 + 21);
    pulse_start();
    step(5);
    pulser_busy = 1'b1;
    step(1);
    check("ovr_set", int'(overrun), 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("ovr_clr_vs_set", int'(overrun), 1);
    step(1);
    pulser_busy = 1'b0;
    step(15);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_fired", int'(fired), 4);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    drained("overrun");

    // Continuous mode stopped on the fifth fire cycle
    period = 32'd10; count = 16'd0; t0 = cyc;
    exp_trig_q.push_back(t0 + 2); exp_trig_q.push_back(t0 + 12);
    exp_trig_q.push_back(t0 + 22); exp_trig_q.push_back(t0 + 32);
    pulse_start();
    step(40);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_running", int'(running), 0);
    check("stop_fired", int'(fired), 4);
    step(15);
    check("stop_still_idle", int'(running), 0);
    drained("stop");

    // Reset during WAIT aborts the sequence
    period = 32'd5; count = 16'd5; t0 = cyc;
    exp_trig_q.push_back(t0 + 2); exp_trig_q.push_back(t0 + 7);
    pulse_start();
    step(8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_idle_zero("midrst");
    step(20);
    drained("midrst");

    // start with stop in IDLE stays IDLE
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_running", int'(running), 0);
    step(5);
    check("startstop_idle", int'(running), 0);

`ifdef TRIG_SEQ_EXT_START_EN
    // External edge starts a sequence 4 clocks later; edges while running ignored
    period = 32'd5; count = 16'd2; t0 = cyc;
    exp_trig_q.push_back(t0 + 4); exp_trig_q.push_back(t0 + 9);
    exp_done_q.push_back(t0 + 10);
    ext_trig = 1'b1;
    step(3);
    ext_trig = 1'b0;
    step(2);
    ext_trig = 1'b1;
    step(3);
    ext_trig = 1'b0;
    step(15);
    check("ext_fired", int'(fired), 2);
    check("ext_idle", int'(running), 0);
    drained("ext");
`else
    // ext_trig has no effect in the default build
    ext_trig = 1'b1;
    step(10);
    ext_trig = 1'b0;
    step(5);
    check("ext_ignored_running", int'(running), 0);
    check("ext_ignored_fired", int'(fired), 0);
    drained("ext");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
